pc_unit: RTL and testbench

Program-counter register and next-PC selector for the single-cycle RISC-V core. Holds the architectural PC, drives it to instruction memory and to the `add4` incrementer, and on each clock loads one of three values: the returned PC+4, a branch target, or a JALR target. It also owns boot, halt and optional misaligned-target trap sequencing, and keeps a retired-instruction counter.

---
 rtl/pc_unit.sv | 134 +++++++++++++
 tb/tb_pc_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: architectural program counter and next-PC selector for the
// single-cycle RISC-V core. Sequences BOOT/RUN/HALT(/TRAP) and counts
// retired instructions. All outputs are registered.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   -> a misaligned redirect target traps to TRAP_VECTOR
//   undefined -> redirect targets are force-aligned, TRAP never entered
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jalr,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [1:0]  state,
  output logic [31:0] retire_count,
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retire_q;
  logic        retire_en;
  logic        pc_valid_q, pc_valid_d;
  logic        misalign_q, misalign_d;
  logic        redirect;
  logic [31:0] target;

  // Select the redirect target: JALR beats a taken branch, JALR bit 0 cleared.
  always_comb begin
    redirect = jalr | branch_taken;
    target   = jalr ? (jalr_target & 32'hFFFF_FFFE) : branch_target;
  end

  // State register plus registered outputs and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // see the pre-edge values of each other, regardless of statement order.
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      misalign_q <= misalign_d;
      if (retire_en) retire_q <= retire_q + 32'd1;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable; without
    // them a missed branch would infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    retire_en = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          // ECALL/EBREAK still retires; execution resumes after it.
          pc_d      = pc_plus4;
          state_d   = ST_HALT;
          retire_en = 1'b1;
        end else if (stall) begin
          // Hold PC; any redirect this cycle is ignored.
          pc_d = pc_q;
        end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (target[1:0] != 2'b00) begin
            pc_d    = TRAP_VECTOR;
            state_d = ST_TRAP;
          end else begin
            pc_d      = target;
            retire_en = 1'b1;
          end
`else
          pc_d      = target & 32'hFFFF_FFFC;
          retire_en = 1'b1;
`endif
        end else begin
          pc_d      = pc_plus4;
          retire_en = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      ST_TRAP: begin
        // One bubble cycle at the trap vector, then execute from it.
        pc_d    = TRAP_VECTOR;
        state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Next values of the registered status outputs.
  always_comb begin
    pc_valid_d = (state_d == ST_RUN);
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = (state_d == ST_TRAP);
`else
    misalign_d = 1'b0;
`endif
  end

  assign pc           = pc_q;
  assign pc_valid     = pc_valid_q;
  assign state        = state_q;
  assign retire_count = retire_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with constant
// expectations, then randomized stimulus against a behavioural model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_TRAP = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jalr;
  logic [31:0] jalr_target;
  logic        stall;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic [1:0]  state;
  logic [31:0] retire_count;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the architectural state.
  logic [1:0]  m_state;
  logic [31:0] m_pc;
  logic [31:0] m_retire;

  always #5 clk = ~clk;

  // add4 incrementer (wraps naturally at 32 bits).
  assign pc_plus4 = pc + 32'd4;

  pc_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jalr(jalr), .jalr_target(jalr_target), .stall(stall),
    .halt_req(halt_req), .resume(resume), .pc(pc), .pc_valid(pc_valid),
    .state(state), .retire_count(retire_count), .misalign(misalign)
  );

  // Architectural rules applied to the inputs sampled at one edge.
  task automatic model_step();
    logic [31:0] dest;
    if (rst) begin
      m_state = S_BOOT; m_pc = RV; m_retire = 0;
    end else begin
      case (m_state)
        S_BOOT: m_state = S_RUN;
        S_HALT: if (resume) m_state = S_RUN;
        S_TRAP: m_state = S_RUN;
        default: begin
          if (halt_req) begin
            m_pc = m_pc + 4; m_retire = m_retire + 1; m_state = S_HALT;
          end else if (!stall) begin
            if (jalr) dest = jalr_target & ~32'h1;
            else if (branch_taken) dest = branch_target;
            else dest = m_pc + 4;
            if ((jalr || branch_taken) && (dest % 4 != 0)) begin
              if (TRAP_EN) begin
                m_pc = TV; m_state = S_TRAP;
              end else begin
                m_pc = dest - (dest % 4); m_retire = m_retire + 1;
              end
            end else begin
              m_pc = dest; m_retire = m_retire + 1;
            end
          end
        end
      endcase
    end
  endtask

  // One clock: advance the model with the sampled inputs, then settle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; branch_taken = 1'b0; branch_target = '0; jalr = 1'b0;
    jalr_target = '0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
    checks++; if (state !== S_BOOT) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_BOOT); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_retire: got %0d want 0", retire_count); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    rst = 1'b0;
  endtask

  task automatic test_boot_sequence();
    tick();
    checks++; if (pc !== 32'h0 || state !== S_RUN || pc_valid !== 1'b1) begin errors++; $display("FAIL boot_run0: pc=%h state=%0d valid=%b want 0/1/1", pc, state, pc_valid); end
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL boot_pc4: got %h want 4", pc); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL boot_pc8: got %h want 8", pc); end
    checks++; if (retire_count !== 32'd2) begin errors++; $display("FAIL boot_retire: got %0d want 2", retire_count); end
  endtask

  task automatic test_jalr_priority();
    branch_taken = 1'b1; branch_target = 32'h40; jalr = 1'b1; jalr_target = 32'h81;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL jalr_priority: got %h want 80", pc); end
    checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL jalr_retire: got %0d want 3", retire_count); end
  endtask

  task automatic test_stall();
    branch_taken = 1'b1; branch_target = 32'h10;
    tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_setup: got %h want 10", pc); end
    stall = 1'b1; branch_target = 32'h200;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'h10 || retire_count !== 32'd4) begin errors++; $display("FAIL stall_hold: pc=%h retire=%0d want 10/4", pc, retire_count); end
    end
    stall = 1'b0;
    tick();
    clear_inputs();
    checks++; if (pc !== 32'h200 || retire_count !== 32'd5) begin errors++; $display("FAIL stall_release: pc=%h retire=%0d want 200/5", pc, retire_count); end
  endtask

  task automatic test_halt();
    branch_taken = 1'b1; branch_target = 32'h20;
    tick();
    clear_inputs();
    halt_req = 1'b1;
    tick();
    checks++; if (pc !== 32'h24 || state !== S_HALT || pc_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: pc=%h state=%0d valid=%b want 24/2/0", pc, state, pc_valid); end
    checks++; if (retire_count !== 32'd7) begin errors++; $display("FAIL halt_retire: got %0d want 7", retire_count); end
    // Further halt requests and redirects are ignored while halted.
    branch_taken = 1'b1; branch_target = 32'h300;
    for (int i = 0; i < 4; i++) begin
      halt_req = i[0];
      tick();
      checks++; if (pc !== 32'h24 || state !== S_HALT || pc_valid !== 1'b0 || retire_count !== 32'd7) begin errors++; $display("FAIL halt_hold: pc=%h state=%0d valid=%b retire=%0d", pc, state, pc_valid, retire_count); end
    end
    clear_inputs();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (pc !== 32'h24 || state !== S_RUN || pc_valid !== 1'b1 || retire_count !== 32'd7) begin errors++; $display("FAIL halt_resume: pc=%h state=%0d valid=%b retire=%0d want 24/1/1/7", pc, state, pc_valid, retire_count); end
  endtask

  task automatic test_misalign();
    jalr = 1'b1; jalr_target = 32'h32;
    tick();
    clear_inputs();
`ifdef PC_MISALIGN_TRAP_EN
    checks++; if (pc !== TV || state !== S_TRAP || misalign !== 1'b1 || pc_valid !== 1'b0) begin errors++; $display("FAIL trap_enter: pc=%h state=%0d mis=%b valid=%b", pc, state, misalign, pc_valid); end
    checks++; if (retire_count !== 32'd7) begin errors++; $display("FAIL trap_retire: got %0d want 7", retire_count); end
    tick();
    checks++; if (pc !== TV || state !== S_RUN || misalign !== 1'b0 || pc_valid !== 1'b1) begin errors++; $display("FAIL trap_exit: pc=%h state=%0d mis=%b valid=%b", pc, state, misalign, pc_valid); end
`else
    checks++; if (pc !== 32'h30 || state !== S_RUN || misalign !== 1'b0) begin errors++; $display("FAIL align_force: pc=%h state=%0d mis=%b want 30/1/0", pc, state, misalign); end
    checks++; if (retire_count !== 32'd8) begin errors++; $display("FAIL align_retire: got %0d want 8", retire_count); end
`endif
  endtask

  task automatic test_reset_mid();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (state !== S_HALT) begin errors++; $display("FAIL rsthalt_setup: state=%0d want 2", state); end
    rst = 1'b1; resume = 1'b1;
    tick();
    clear_inputs();
    checks++; if (pc !== RV || state !== S_BOOT || retire_count !== 32'd0 || pc_valid !== 1'b0) begin errors++; $display("FAIL rst_in_halt: pc=%h state=%0d retire=%0d valid=%b", pc, state, retire_count, pc_valid); end
`ifdef PC_MISALIGN_TRAP_EN
    tick();
    tick();
    jalr = 1'b1; jalr_target = 32'h32;
    tick();
    clear_inputs();
    checks++; if (state !== S_TRAP) begin errors++; $display("FAIL rsttrap_setup: state=%0d want 3", state); end
    rst = 1'b1;
    tick();
    clear_inputs();
    checks++; if (pc !== RV || state !== S_BOOT || retire_count !== 32'd0 || misalign !== 1'b0) begin errors++; $display("FAIL rst_in_trap: pc=%h state=%0d retire=%0d mis=%b", pc, state, retire_count, misalign); end
`endif
  endtask

  task automatic test_random();
    clear_inputs();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      stall         = ($urandom_range(0, 7) == 0);
      halt_req      = ($urandom_range(0, 15) == 0);
      resume        = ($urandom_range(0, 3) == 0);
      jalr          = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      jalr_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      branch_target = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      tick();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc cycle %0d: got %h want %h", i, pc, m_pc); end
      checks++; if (state !== m_state) begin errors++; $display("FAIL rand_state cycle %0d: got %0d want %0d", i, state, m_state); end
      checks++; if (pc_valid !== (m_state == S_RUN)) begin errors++; $display("FAIL rand_valid cycle %0d: got %b want %b", i, pc_valid, m_state == S_RUN); end
      checks++; if (misalign !== (m_state == S_TRAP)) begin errors++; $display("FAIL rand_misalign cycle %0d: got %b want %b", i, misalign, m_state == S_TRAP); end
      checks++; if (retire_count !== m_retire) begin errors++; $display("FAIL rand_retire cycle %0d: got %0d want %0d", i, retire_count, m_retire); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_boot_sequence();
    test_jalr_priority();
    test_stall();
    test_halt();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
